// File: rtl/counter_mon_pkg.sv
// Shared types and fault codes for the up/down counter monitor.
package counter_mon_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StTrack,
      StFault
   } mon_state_e;

   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_RST  = 3'd1;
   localparam logic [2:0] ERR_HOLD = 3'd2;
   localparam logic [2:0] ERR_UP   = 3'd3;
   localparam logic [2:0] ERR_DOWN = 3'd4;
   localparam logic [2:0] ERR_WRAP = 3'd5;

endpackage

// File: rtl/count_predictor.sv
// Combinational prediction of the observed counter's value one cycle after the sampled controls.
module count_predictor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             prev_rst,
   input  logic             prev_en,
   input  logic             prev_dir,
   input  logic [WIDTH-1:0] prev_cnt,
   output logic [WIDTH-1:0] expected,
   output logic             wrapped
);

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   always_comb begin
      expected = prev_cnt;
      wrapped  = 1'b0;
      if (prev_rst) begin
         expected = '0;
      end else if (prev_en) begin
         if (prev_dir) begin
            expected = prev_cnt + One;
            wrapped  = &prev_cnt;
         end else begin
            expected = prev_cnt - One;
            wrapped  = ~|prev_cnt;
         end
      end
   end

endmodule

// File: rtl/updown_counter_monitor.sv
// In-system checker for an up/down counter: predicts each count from the previous cycle's
// controls and records mismatches as a sticky flag, code, saturating count and first-fault capture.
module updown_counter_monitor
   import counter_mon_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned ERRCNT_W = 8,
   parameter bit          WRAP_OK  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mon_rst,
   input  logic                mon_enable,
   input  logic                mon_direction,
   input  logic [WIDTH-1:0]    mon_count,
   input  logic                clear_err,
   output logic                armed,
   output logic                err,
   output logic                err_pulse,
   output logic [2:0]          err_code,
   output logic [ERRCNT_W-1:0] err_count,
   output logic [WIDTH-1:0]    first_exp,
   output logic [WIDTH-1:0]    first_obs
);

   localparam logic [ERRCNT_W-1:0] CntOne = ERRCNT_W'(1);

   mon_state_e          state_q, state_d;
   logic                prev_rst_q, prev_en_q, prev_dir_q;
   logic [WIDTH-1:0]    prev_cnt_q;
   logic                err_pulse_q;
   logic [2:0]          err_code_q, err_code_d;
   logic [ERRCNT_W-1:0] err_count_q, err_count_d;
   logic [WIDTH-1:0]    first_exp_q, first_exp_d, first_obs_q, first_obs_d;

   logic [WIDTH-1:0] expected;
   logic             wrapped, step_bad, mismatch;
   logic [2:0]       mis_code;

   count_predictor #(
      .WIDTH(WIDTH)
   ) u_predictor (
      .prev_rst (prev_rst_q),
      .prev_en  (prev_en_q),
      .prev_dir (prev_dir_q),
      .prev_cnt (prev_cnt_q),
      .expected (expected),
      .wrapped  (wrapped)
   );

   assign armed    = (state_q != StIdle);
   assign step_bad = (mon_count != expected);
   // A correct step that wraps is only a fault when wrapping is disallowed.
   assign mismatch = armed && (step_bad || (!WRAP_OK && wrapped));

   always_comb begin
      mis_code = ERR_WRAP;
      if (prev_rst_q) begin
         mis_code = ERR_RST;
      end else if (!prev_en_q) begin
         mis_code = ERR_HOLD;
      end else if (step_bad) begin
         mis_code = prev_dir_q ? ERR_UP : ERR_DOWN;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  state_d = StTrack;
         StTrack: if (mismatch) state_d = StFault;
         StFault: if (clear_err && !mismatch) state_d = StTrack;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      err_code_d  = err_code_q;
      err_count_d = err_count_q;
      first_exp_d = first_exp_q;
      first_obs_d = first_obs_q;
      if (clear_err) begin
         err_code_d  = ERR_NONE;
         err_count_d = '0;
         first_exp_d = '0;
         first_obs_d = '0;
      end
      if (mismatch) begin
         err_code_d = mis_code;
         if (err_count_d != {ERRCNT_W{1'b1}}) begin
            err_count_d = err_count_d + CntOne;
         end
         // Capture reloads on entry to FAULT, or when a clear collides with a new fault.
         if (state_q == StTrack || clear_err) begin
            first_exp_d = expected;
            first_obs_d = mon_count;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         prev_rst_q  <= 1'b0;
         prev_en_q   <= 1'b0;
         prev_dir_q  <= 1'b0;
         prev_cnt_q  <= '0;
         err_pulse_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         err_count_q <= '0;
         first_exp_q <= '0;
         first_obs_q <= '0;
      end else begin
         state_q     <= state_d;
         prev_rst_q  <= mon_rst;
         prev_en_q   <= mon_enable;
         prev_dir_q  <= mon_direction;
         prev_cnt_q  <= mon_count;
         err_pulse_q <= mismatch;
         err_code_q  <= err_code_d;
         err_count_q <= err_count_d;
         first_exp_q <= first_exp_d;
         first_obs_q <= first_obs_d;
      end
   end

   assign err       = (state_q == StFault);
   assign err_pulse = err_pulse_q;
   assign err_code  = err_code_q;
   assign err_count = err_count_q;
   assign first_exp = first_exp_q;
   assign first_obs = first_obs_q;

endmodule

// File: tb/tb_updown_counter_monitor.sv
// Scoreboard bench: two monitor instances (wrap legal / 2-bit error count with wrap illegal)
// share one stimulus stream; a behavioural model queues expected outputs per cycle.
module tb_updown_counter_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mon_rst = 1'b0;
   logic       mon_enable = 1'b0;
   logic       mon_direction = 1'b0;
   logic [7:0] mon_count = 8'd0;
   logic       clear_err = 1'b0;

   logic       a_armed, a_err, a_pulse, b_armed, b_err, b_pulse;
   logic [2:0] a_code, b_code;
   logic [7:0] a_cnt, a_fe, a_fo, b_fe, b_fo;
   logic [1:0] b_cnt;

   always #5 clk = ~clk;

   updown_counter_monitor #(.WIDTH(8), .ERRCNT_W(8), .WRAP_OK(1'b1)) dut_a (
      .clk(clk), .rst(rst), .mon_rst(mon_rst), .mon_enable(mon_enable),
      .mon_direction(mon_direction), .mon_count(mon_count), .clear_err(clear_err),
      .armed(a_armed), .err(a_err), .err_pulse(a_pulse), .err_code(a_code),
      .err_count(a_cnt), .first_exp(a_fe), .first_obs(a_fo)
   );

   updown_counter_monitor #(.WIDTH(8), .ERRCNT_W(2), .WRAP_OK(1'b0)) dut_b (
      .clk(clk), .rst(rst), .mon_rst(mon_rst), .mon_enable(mon_enable),
      .mon_direction(mon_direction), .mon_count(mon_count), .clear_err(clear_err),
      .armed(b_armed), .err(b_err), .err_pulse(b_pulse), .err_code(b_code),
      .err_count(b_cnt), .first_exp(b_fe), .first_obs(b_fo)
   );

   typedef struct {
      bit armed;
      bit err;
      bit pulse;
      int code;
      int cnt;
      int fe;
      int fo;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state: history of the previous sample plus per-instance error records.
   bit m_armed;
   bit p_rst, p_en, p_dir;
   int p_cnt;
   bit m_fault[2];
   bit m_pulse[2];
   int m_code[2], m_cnt[2], m_fe[2], m_fo[2];
   bit wrap_ok[2] = '{1'b1, 1'b0};
   int cnt_max[2] = '{255, 3};

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int exp_cnt, code;
      bit wrapped, bad, was_fault;
      exp_t e;
      if (rst) begin
         m_armed = 0;
         {p_rst, p_en, p_dir} = 3'b000;
         p_cnt = 0;
         for (int v = 0; v < 2; v++) begin
            m_fault[v] = 0; m_pulse[v] = 0; m_code[v] = 0; m_cnt[v] = 0;
            m_fe[v] = 0; m_fo[v] = 0;
         end
      end else begin
         if (p_rst) exp_cnt = 0;
         else if (!p_en) exp_cnt = p_cnt;
         else exp_cnt = (p_cnt + (p_dir ? 1 : -1) + 256) % 256;
         wrapped = !p_rst && p_en && (p_dir ? (p_cnt == 255) : (p_cnt == 0));
         for (int v = 0; v < 2; v++) begin
            bad = m_armed && ((int'(mon_count) != exp_cnt) || (!wrap_ok[v] && wrapped));
            if (p_rst) code = 1;
            else if (!p_en) code = 2;
            else if (int'(mon_count) != exp_cnt) code = p_dir ? 3 : 4;
            else code = 5;
            was_fault = m_fault[v];
            m_pulse[v] = bad;
            if (clear_err) begin
               m_fault[v] = 0; m_code[v] = 0; m_cnt[v] = 0; m_fe[v] = 0; m_fo[v] = 0;
            end
            if (bad) begin
               if (!was_fault || clear_err) begin
                  m_fe[v] = exp_cnt;
                  m_fo[v] = int'(mon_count);
               end
               m_fault[v] = 1;
               m_code[v]  = code;
               m_cnt[v]   = (m_cnt[v] < cnt_max[v]) ? m_cnt[v] + 1 : cnt_max[v];
            end
         end
         m_armed = 1;
         p_rst = mon_rst; p_en = mon_enable; p_dir = mon_direction;
         p_cnt = int'(mon_count);
      end
      for (int v = 0; v < 2; v++) begin
         e.armed = m_armed; e.err = m_fault[v]; e.pulse = m_pulse[v]; e.code = m_code[v];
         e.cnt = m_cnt[v]; e.fe = m_fe[v]; e.fo = m_fo[v];
         if (v == 0) qa.push_back(e);
         else qb.push_back(e);
      end
   endtask

   task automatic drive(input bit r, input bit mr, input bit en, input bit dir,
                        input int c, input bit clr);
      @(negedge clk);
      rst = r; mon_rst = mr; mon_enable = en; mon_direction = dir;
      mon_count = 8'(c); clear_err = clr;
      model_step();
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: each clock the DUTs present a new output set; compare against the queue head.
   initial begin
      exp_t ea, eb;
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() > 0 && qb.size() > 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            chk("a.armed", int'(a_armed), int'(ea.armed));
            chk("a.err", int'(a_err), int'(ea.err));
            chk("a.err_pulse", int'(a_pulse), int'(ea.pulse));
            chk("a.err_code", int'(a_code), ea.code);
            chk("a.err_count", int'(a_cnt), ea.cnt);
            chk("a.first_exp", int'(a_fe), ea.fe);
            chk("a.first_obs", int'(a_fo), ea.fo);
            chk("b.armed", int'(b_armed), int'(eb.armed));
            chk("b.err", int'(b_err), int'(eb.err));
            chk("b.err_pulse", int'(b_pulse), int'(eb.pulse));
            chk("b.err_code", int'(b_code), eb.code);
            chk("b.err_count", int'(b_cnt), eb.cnt);
            chk("b.first_exp", int'(b_fe), eb.fe);
            chk("b.first_obs", int'(b_fo), eb.fo);
         end
      end
   end

   initial begin
      int nxt, c;
      bit r, mr, en, dir, clr;

      // Clean run: up 0..3, down to 1, then an observed-counter reset.
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      settle();
      chk("reset.armed", int'(a_armed), 0);
      drive(0, 0, 1, 1, 0, 0);
      settle();
      chk("first_sample.armed", int'(a_armed), 1);
      drive(0, 0, 1, 1, 1, 0);
      drive(0, 0, 1, 1, 2, 0);
      drive(0, 0, 1, 0, 3, 0);
      drive(0, 0, 1, 0, 2, 0);
      drive(0, 1, 1, 0, 1, 0);
      drive(0, 0, 0, 1, 0, 0);
      settle();
      chk("clean.err", int'(a_err), 0);

      // Hold fault: disabled at 5, observed 6.
      drive(0, 0, 1, 1, 0, 0);
      for (int k = 1; k <= 4; k++) drive(0, 0, 1, 1, k, 0);
      drive(0, 0, 0, 1, 5, 0);
      drive(0, 0, 0, 1, 6, 0);
      settle();
      chk("hold.err_pulse", int'(a_pulse), 1);
      chk("hold.err_code", int'(a_code), 2);
      chk("hold.first_exp", int'(a_fe), 5);
      chk("hold.first_obs", int'(a_fo), 6);

      // Step faults: up from 7 observed 9, then two more skips.
      drive(0, 0, 1, 1, 6, 1);
      drive(0, 0, 1, 1, 7, 0);
      drive(0, 0, 1, 1, 9, 0);
      settle();
      chk("step.err_code", int'(a_code), 3);
      chk("step.err_count1", int'(a_cnt), 1);
      drive(0, 0, 1, 1, 12, 0);
      drive(0, 0, 1, 1, 15, 0);
      settle();
      chk("step.err_count3", int'(a_cnt), 3);
      drive(0, 0, 1, 1, 16, 1);

      // Wrap 255 -> 0: legal on dut_a, ERR_WRAP on dut_b.
      drive(0, 0, 0, 1, 254, 0);
      drive(0, 0, 1, 1, 254, 1);
      drive(0, 0, 1, 1, 255, 0);
      drive(0, 0, 1, 0, 0, 0);
      settle();
      chk("wrap_ok.err", int'(a_err), 0);
      chk("wrap_bad.err_code", int'(b_code), 5);

      // Saturation: five hold faults against the 2-bit counter, then clear.
      drive(1, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      for (int k = 1; k <= 5; k++) drive(0, 0, 0, 1, k, 0);
      settle();
      chk("sat.b_err_count", int'(b_cnt), 3);
      chk("sat.a_err_count", int'(a_cnt), 5);
      drive(0, 0, 0, 1, 5, 1);
      settle();
      chk("clear.err", int'(b_err), 0);
      chk("clear.err_count", int'(b_cnt), 0);

      // Clear colliding with a new fault, then reset from FAULT.
      drive(0, 0, 0, 1, 6, 0);
      drive(0, 0, 0, 1, 9, 1);
      settle();
      chk("collide.err", int'(a_err), 1);
      chk("collide.err_count", int'(a_cnt), 1);
      chk("collide.first_exp", int'(a_fe), 6);
      chk("collide.first_obs", int'(a_fo), 9);
      drive(1, 0, 0, 1, 9, 0);
      settle();
      chk("rst_fault.armed", int'(a_armed), 0);
      chk("rst_fault.err", int'(a_err), 0);
      chk("rst_fault.err_count", int'(a_cnt), 0);
      drive(0, 0, 0, 1, 0, 0);
      settle();
      chk("rearm.armed", int'(a_armed), 1);

      // Randomised traffic from a well-behaved counter with occasional corruption.
      nxt = 0;
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(0, 49) == 0);
         mr  = ($urandom_range(0, 9) == 0);
         en  = ($urandom_range(0, 3) != 0);
         dir = $urandom_range(0, 1) != 0;
         clr = ($urandom_range(0, 15) == 0);
         c   = nxt;
         if ($urandom_range(0, 7) == 0) c = c ^ int'($urandom_range(1, 255));
         drive(r, mr, en, dir, c, clr);
         nxt = mr ? 0 : (en ? (c + (dir ? 1 : 255)) % 256 : c);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard.drained", qa.size() + qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
